// File: rtl/bf16_pkg.sv
// Shared BF16 definitions: field widths, special encodings, accumulator FSM states
// and the canonicalisation helper used on the first element of a vector.
package bf16_pkg;

  localparam int unsigned DATA_TYPE = 16;
  localparam int unsigned COUNT_W   = 16;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MAN_W     = 7;
  localparam int unsigned BIAS      = 127;
  localparam int unsigned SIG_W     = MAN_W + 1;
  // significand plus guard, round and sticky
  localparam int unsigned EXT_W     = SIG_W + 3;

  localparam logic [DATA_TYPE-1:0] BF16_QNAN = 16'h7FC0;
  localparam logic [DATA_TYPE-1:0] BF16_PINF = 16'h7F80;
  localparam logic [DATA_TYPE-1:0] BF16_NINF = 16'hFF80;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } acc_state_t;

  // Denormals become a same-sign zero, every NaN becomes the canonical quiet NaN.
  function automatic logic [DATA_TYPE-1:0] bf16_canon(input logic [DATA_TYPE-1:0] x);
    logic [DATA_TYPE-1:0] r;
    r = x;
    if (x[DATA_TYPE-2:MAN_W] == '0) begin
      r = {x[DATA_TYPE-1], (DATA_TYPE-1)'(0)};
    end else if (x[DATA_TYPE-2:MAN_W] == '1 && x[MAN_W-1:0] != '0) begin
      r = BF16_QNAN;
    end
    return r;
  endfunction

endpackage

// File: rtl/bf16_accumulator_if.sv
// Product-in / sum-out stream bundle between the multiplier, accumulator and consumer.
interface bf16_accumulator_if;
  import bf16_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_TYPE-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_TYPE-1:0] out_data;
  logic [COUNT_W-1:0]   out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/bf16_adder.sv
// Combinational BF16 adder: flush-to-zero inputs/outputs, RNE rounding, IEEE specials.
module bf16_adder
  import bf16_pkg::*;
(
  input  logic [DATA_TYPE-1:0] a,
  input  logic [DATA_TYPE-1:0] b,
  output logic [DATA_TYPE-1:0] o
);

  logic             sa, sb, za, zb, na, nb, ia, ib;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;

  logic             a_big, s_big, found, up, zero_res;
  logic [EXP_W-1:0] e_big, e_sml, diff;
  logic [MAN_W-1:0] m_big, m_sml, man_r;
  logic [EXT_W-1:0] big_x, sml_f, sml_x, dif_x, norm;
  logic [EXT_W:0]   sum_x;
  logic [3:0]       lz;
  logic [MAN_W:0]   man_c;
  logic [EXP_W+1:0] exp_w;

  assign sa = a[DATA_TYPE-1];
  assign sb = b[DATA_TYPE-1];
  assign ea = a[DATA_TYPE-2:MAN_W];
  assign eb = b[DATA_TYPE-2:MAN_W];
  assign ma = a[MAN_W-1:0];
  assign mb = b[MAN_W-1:0];
  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = (ea == '1) && (ma == '0);
  assign ib = (eb == '1) && (mb == '0);
  assign na = (ea == '1) && (ma != '0);
  assign nb = (eb == '1) && (mb != '0);

  always_comb begin
    a_big    = {ea, ma} >= {eb, mb};
    s_big    = a_big ? sa : sb;
    e_big    = a_big ? ea : eb;
    m_big    = a_big ? ma : mb;
    e_sml    = a_big ? eb : ea;
    m_sml    = a_big ? mb : ma;
    diff     = e_big - e_sml;
    big_x    = {1'b1, m_big, 3'b000};
    sml_f    = {1'b1, m_sml, 3'b000};
    sum_x    = '0;
    dif_x    = '0;
    norm     = '0;
    lz       = '0;
    found    = 1'b0;
    zero_res = 1'b0;
    exp_w    = {2'b00, e_big};

    // Align the smaller operand; everything shifted out collapses into the sticky bit.
    if (diff >= EXP_W'(EXT_W)) begin
      sml_x = EXT_W'(1);
    end else begin
      sml_x    = sml_f >> diff;
      sml_x[0] = sml_x[0] | (|(sml_f & ~({EXT_W{1'b1}} << diff)));
    end

    if (sa == sb) begin
      sum_x = {1'b0, big_x} + {1'b0, sml_x};
      if (sum_x[EXT_W]) begin
        norm  = {sum_x[EXT_W:2], |sum_x[1:0]};
        exp_w = exp_w + (EXP_W+2)'(1);
      end else begin
        norm = sum_x[EXT_W-1:0];
      end
    end else begin
      dif_x = big_x - sml_x;
      for (int i = EXT_W - 1; i >= 0; i--) begin
        if (!found && dif_x[i]) begin
          lz    = 4'(EXT_W - 1 - i);
          found = 1'b1;
        end
      end
      norm = dif_x << lz;
      if (!found || {6'd0, lz} >= exp_w) begin
        zero_res = 1'b1;
      end
      exp_w = exp_w - {6'd0, lz};
    end

    if (!norm[EXT_W-1]) begin
      zero_res = 1'b1;
    end

    // Round to nearest, ties to even; a mantissa carry bumps the exponent.
    up    = norm[2] & (norm[3] | (|norm[1:0]));
    man_c = {1'b0, norm[EXT_W-2:3]} + (MAN_W+1)'(up);
    exp_w = exp_w + (EXP_W+2)'(man_c[MAN_W]);
    man_r = man_c[MAN_W-1:0];

    if (na || nb || (ia && ib && (sa != sb))) begin
      o = BF16_QNAN;
    end else if (ia) begin
      o = a;
    end else if (ib) begin
      o = b;
    end else if (za && zb) begin
      o = {sa & sb, (DATA_TYPE-1)'(0)};
    end else if (za) begin
      o = b;
    end else if (zb) begin
      o = a;
    end else if (zero_res) begin
      o = '0;
    end else if (exp_w >= (EXP_W+2)'(255)) begin
      o = s_big ? BF16_NINF : BF16_PINF;
    end else begin
      o = {s_big, exp_w[EXP_W-1:0], man_r};
    end
  end

endmodule

// File: rtl/bf16_accumulator.sv
// Streaming BF16 vector reduction: sums one in_last-delimited vector per result,
// with element count, over valid/ready handshakes on both sides.
module bf16_accumulator
  import bf16_pkg::*;
(
  input  logic              CLK,
  input  logic              rst,
  bf16_accumulator_if.slave bus
);

  acc_state_t           state_q, state_d;
  logic [DATA_TYPE-1:0] acc_q, acc_d;
  logic [DATA_TYPE-1:0] out_data_q, out_data_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [COUNT_W-1:0]   out_count_q, out_count_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_TYPE-1:0] sum_c, first_c;
  logic                 in_ready_c, beat_c, xfer_c;

  bf16_adder u_adder (
    .a (acc_q),
    .b (bus.in_data),
    .o (sum_c)
  );

  assign in_ready_c    = (state_q != DONE) || bus.out_ready;
  assign beat_c        = bus.in_valid && in_ready_c;
  assign xfer_c        = out_valid_q && bus.out_ready;
  assign first_c       = bf16_canon(bus.in_data);

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  // A beat in IDLE, or in DONE alongside the result transfer, starts a new vector.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && xfer_c) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
        if (beat_c) begin
          acc_d   = first_c;
          count_d = COUNT_W'(1);
          state_d = bus.in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (beat_c) begin
          acc_d   = sum_c;
          count_d = (&count_q) ? count_q : count_q + COUNT_W'(1);
          state_d = bus.in_last ? DONE : ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase

    if (beat_c && bus.in_last) begin
      out_data_d  = acc_d;
      out_count_d = count_d;
      out_valid_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_bf16_accumulator.sv
// Directed bench for bf16_accumulator: table of short vectors plus handshake,
// reset and counter-saturation sequences.
module tb_bf16_accumulator;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          n;
    logic [15:0] exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NVEC = 14;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   beats;
  int   xfers;

  bf16_accumulator_if bus ();

  bf16_accumulator dut (
    .CLK (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) beats++;
    if (bus.out_valid && bus.out_ready) xfers++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = v.a;
    bus.in_last   = (v.n == 1);
    step();
    if (v.n == 2) begin
      bus.in_data = v.b;
      bus.in_last = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check($sformatf("vec%0d_valid", idx), 32'(bus.out_valid), 32'd1);
    check($sformatf("vec%0d_data", idx), 32'(bus.out_data), 32'(v.exp_data));
    check($sformatf("vec%0d_count", idx), 32'(bus.out_count), 32'(v.exp_cnt));
    step();
    check($sformatf("vec%0d_drain", idx), 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    vec_t vecs[NVEC];
    int   b0, x0;

    n_checks = 0;
    n_fail   = 0;
    beats    = 0;
    xfers    = 0;

    vecs[0]  = '{16'h4040, 16'h4048, 2, 16'h40C4, 16'd2};
    vecs[1]  = '{16'h4380, 16'h3F80, 2, 16'h4380, 16'd2};
    vecs[2]  = '{16'h4380, 16'h4040, 2, 16'h4382, 16'd2};
    vecs[3]  = '{16'h4040, 16'hC040, 2, 16'h0000, 16'd2};
    vecs[4]  = '{16'h7F7F, 16'h7F7F, 2, 16'h7F80, 16'd2};
    vecs[5]  = '{16'h7F80, 16'hFF80, 2, 16'h7FC0, 16'd2};
    vecs[6]  = '{16'h0001, 16'h0000, 1, 16'h0000, 16'd1};
    vecs[7]  = '{16'h8000, 16'h8000, 2, 16'h8000, 16'd2};
    vecs[8]  = '{16'h7F80, 16'h3F80, 2, 16'h7F80, 16'd2};
    vecs[9]  = '{16'h7F81, 16'h0000, 1, 16'h7FC0, 16'd1};
    vecs[10] = '{16'hC000, 16'h3F80, 2, 16'hBF80, 16'd2};
    vecs[11] = '{16'h3F80, 16'h0001, 2, 16'h3F80, 16'd2};
    vecs[12] = '{16'h3F80, 16'hBF80, 2, 16'h0000, 16'd2};
    vecs[13] = '{16'hFF7F, 16'hFF7F, 2, 16'hFF80, 16'd2};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_count", 32'(bus.out_count), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Backpressure: result must hold and input must stall while out_ready is low.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h4040;
    bus.in_last   = 1'b0;
    step();
    bus.in_last = 1'b1;
    step();
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    check("bp_data", 32'(bus.out_data), 32'h40C0);
    check("bp_count", 32'(bus.out_count), 32'd2);
    b0 = beats;
    x0 = xfers;
    bus.in_data = 16'h3F80;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_in_ready%0d", i), 32'(bus.in_ready), 32'd0);
      step();
      check($sformatf("bp_hold_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_hold_data%0d", i), 32'(bus.out_data), 32'h40C0);
      check($sformatf("bp_hold_count%0d", i), 32'(bus.out_count), 32'd2);
    end
    check("bp_no_beat", 32'(beats - b0), 32'd0);
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("bp_one_xfer", 32'(xfers - x0), 32'd1);

    // Back-to-back: new first beat accepted in the same cycle as the transfer.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h4100;
    bus.in_last  = 1'b1;
    step();
    bus.in_data = 16'h3F80;
    bus.in_last = 1'b0;
    #1;
    check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    b0 = beats;
    x0 = xfers;
    step();
    check("b2b_accept", 32'(beats - b0), 32'd1);
    check("b2b_xfer", 32'(xfers - x0), 32'd1);
    check("b2b_mid_valid", 32'(bus.out_valid), 32'd0);
    bus.in_last = 1'b1;
    step();
    check("b2b_data", 32'(bus.out_data), 32'h4000);
    check("b2b_count", 32'(bus.out_count), 32'd2);
    // Single-element vector during transfer keeps the block in DONE.
    bus.in_data = 16'h4100;
    step();
    check("b2b_single_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_single_data", 32'(bus.out_data), 32'h4100);
    check("b2b_single_count", 32'(bus.out_count), 32'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    step();
    check("b2b_drain", 32'(bus.out_valid), 32'd0);

    // Idle cycles inside a vector leave the partial sum untouched.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h3F80;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("gap_data", 32'(bus.out_data), 32'h4000);
    check("gap_count", 32'(bus.out_count), 32'd2);
    step();

    // Asynchronous reset mid-vector clears outputs without a clock edge.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h3F80;
    for (int i = 0; i < 3; i++) step();
    bus.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data", 32'(bus.out_data), 32'd0);
    check("mid_rst_count", 32'(bus.out_count), 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    run_vec('{16'h4100, 16'h0000, 1, 16'h4100, 16'd1}, 100);

    // Counter saturation: 65537 elements report all-ones, sum still tracks.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      bus.in_data = (i == 65536) ? 16'h3F80 : 16'h0000;
      bus.in_last = (i == 65536);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("sat_count", 32'(bus.out_count), 32'h0000FFFF);
    check("sat_data", 32'(bus.out_data), 32'h3F80);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bf16_accumulator.md
# bf16_accumulator

Streaming BF16 reduction stage that sits directly downstream of `bf16_multiplier`. It consumes one product per cycle over a valid/ready handshake and sums the products of one vector, delimited by `in_last`, into a single BF16 result. It emits that result with the element count over a second valid/ready handshake, so multiplier plus accumulator form one dot-product lane.

## Interface
- `DATA_TYPE`, 16: operand/result width; BF16 only (1 sign, 8 exponent, 7 mantissa).
- `COUNT_W`, 16: width of the element counter.
- `CLK` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset. One clock; reset is asynchronous and active-low.
- `in_valid` input 1: `in_data` / `in_last` are valid.
- `in_ready` output 1: the block accepts a beat this cycle.
- `in_data` input DATA_TYPE: BF16 product from the multiplier.
- `in_last` input 1: this beat is the final element of the vector.
- `out_valid` output 1: the result is valid.
- `out_ready` input 1: the consumer accepts the result.
- `out_data` output DATA_TYPE: BF16 sum.
- `out_count` output COUNT_W: number of elements summed; saturates at all-ones.

## Operation
- A beat is accepted when `in_valid && in_ready`. The output transfers when `out_valid && out_ready`.
- FSM states:
  - IDLE: no partial sum.
  - ACCUM: partial sum held.
  - DONE: result held on the outputs.
- IDLE + beat: `acc <= canon(in_data)`, `count <= 1`. Next state is DONE if `in_last`, else ACCUM.
- ACCUM + beat: `acc <= bf16_add(acc, in_data)`, count increments. Next state is DONE if `in_last`.
- Entering DONE: `out_data <= ` the new acc value, `out_count <=` the new count, `out_valid <= 1`.
- DONE + output transfer with no beat: return to IDLE, `out_valid <= 0`.
- DONE + output transfer + beat in the same cycle: the beat is treated as the first element of a new vector, exactly as from IDLE. If it carries `in_last`, the block stays in DONE with the new result.
- `in_ready = (state != DONE) || out_ready` (combinational).
- `canon(x)`:
  - denormals flush to a same-sign zero;
  - any NaN becomes `16'h7FC0`;
  - all other values pass through unchanged.
- `bf16_add` rules:
  - Denormal inputs are flushed to zero, and denormal results flush to +0.
  - Alignment shift carries guard, round and sticky bits; rounding is round-to-nearest-even.
  - An exponent overflow after rounding gives ±inf (`7F80` / `FF80`).
  - Any NaN input, or +inf plus -inf, gives `7FC0`.
  - inf plus a finite value gives that inf.
  - Exact cancellation gives `+0` (`0000`). `-0 + -0` gives `-0`.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_count` = 0;
  - FSM = IDLE, so `in_ready` = 1 once `rst` is high.
- Throughput is one beat per cycle. The add path is combinational between the acc register and its next-state value, with no pipeline hazard.
- Latency: `out_valid` rises on the edge after the `in_last` beat is accepted.
- While DONE with `out_ready` low:
  - `in_ready` = 0;
  - `out_data`, `out_count` and `out_valid` hold stable, for any number of cycles.
- A single-element vector (first beat has `in_last`) gives `out_data = canon(in_data)` and `out_count = 1`.
- Cycles with `in_valid` low in ACCUM leave acc and count unchanged.
- Reset asserted mid-vector or in DONE discards the partial sum and any pending result. All outputs take their reset values immediately, without waiting for `CLK`.
- Counter saturation: `out_count` holds at all-ones; the sum keeps accumulating.

## Structure
- Shared package `bf16_pkg` holds:
  - the field-width localparams (`EXP_W` = 8, `MAN_W` = 7, `BIAS` = 127);
  - `BF16_QNAN` = `16'h7FC0`, `BF16_PINF` = `16'h7F80`, `BF16_NINF` = `16'hFF80`;
  - the FSM state enum `acc_state_t` {IDLE, ACCUM, DONE}.
- Sub-module `bf16_adder` is purely combinational (A, B -> O). It is reusable by later adder-tree stages.
- The top level holds the FSM, the acc, count and output registers, and the handshake logic.

## Test plan
- Basic sum: beats `4040`, then `4048`+last, with `out_ready` = 1 → one cycle later `out_data` = `40C4` (6.125), `out_count` = 2.
- Rounding, run as two separate vectors:
  - `4380` + `3F80` (256+1) → `4380` (tie resolves to even);
  - `4380` + `4040` (256+3) → `4382` (260).
- Special values, each a separate vector:
  - `4040` + `C040` → `0000`;
  - `7F7F` + `7F7F` → `7F80`;
  - `7F80` + `FF80` → `7FC0`;
  - a denormal `0001`+last alone → `0000`, count 1.
- Backpressure: hold `out_ready` = 0 for 3 cycles after the result →
  - `out_valid` stays 1 and `out_data` is stable;
  - `in_ready` = 0 and no beat is accepted;
  - on release, exactly one output transfer occurs.
- Back-to-back vectors: while DONE with `out_ready` = 1, present a new first beat `3F80` → it is accepted in the same cycle. A following `3F80`+last → `out_data` = `4000`, count 2.
- Reset mid-vector: after 3 beats, pulse `rst` low between clock edges → `out_valid`, `out_data` and `out_count` go to 0 immediately. A new vector `4100`+last → `4100`, count 1.
